// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Constants and feeder state type shared by the TPU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int LANE_W     = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int LANES      = DATA_WIDTH / LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with synchronous clear and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ub_act_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ub_act_feeder
//  Description : Bursts rows out of the unified buffer and streams them to the
//                systolic array as diagonally skewed activation beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ub_act_feeder
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  ub_rd_en,
    output logic [ADDR_WIDTH:0]   ub_rd_addr,
    output logic [ADDR_WIDTH:0]   ub_rd_count,
    input  logic [DATA_WIDTH-1:0] ub_rd_data,
    input  logic                  ub_rd_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int                AW         = ADDR_WIDTH + 1;
    localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int                DRN_W      = $clog2(LANES);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(LANES - 2);

    feeder_state_e          state_q, state_d;
    logic                   bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]  next_idx_q, next_idx_d;
    logic [AW-1:0]          req_rem_q, req_rem_d;
    logic [AW-1:0]          pop_rem_q, pop_rem_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [DRN_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [AW-1:0]          rd_count_q, rd_count_d;
    logic                   out_valid_q, out_valid_d;

    logic                   w_clr;
    logic                   w_adv;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic [CNT_W-1:0]       w_free;
    logic [AW-1:0]          w_burst;
    logic [CNT_W-1:0]       w_cnt_d;
    logic [DATA_WIDTH-1:0]  w_head;
    logic [DATA_WIDTH-1:0]  w_skew_in;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_capture_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .push_i  (w_push),
        .wdata_i (ub_rd_data),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_adv   = out_valid_q && out_ready;
    assign w_pop   = w_adv && (state_q == ST_RUN);
    assign w_push  = ub_rd_valid && (outstanding_q != '0) && (!w_full || w_pop);
    assign w_free  = DEPTH_C - w_count;
    assign w_burst = (req_rem_q < AW'(w_free)) ? req_rem_q : AW'(w_free);
    // One burst in flight; its slots are reserved up front so pushes never overflow.
    assign w_issue = (state_q == ST_RUN) && (outstanding_q == '0) &&
                     (req_rem_q != '0) && (w_free != '0);

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        next_idx_d    = next_idx_q;
        req_rem_d     = req_rem_q;
        pop_rem_d     = pop_rem_q;
        outstanding_d = outstanding_q;
        drain_cnt_d   = drain_cnt_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_count_d    = rd_count_q;
        w_clr         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bank_d        = base_addr[ADDR_WIDTH];
                    next_idx_d    = base_addr[ADDR_WIDTH-1:0];
                    req_rem_d     = num_words;
                    pop_rem_d     = num_words;
                    outstanding_d = '0;
                    drain_cnt_d   = '0;
                    w_clr         = 1'b1;
                    state_d       = (num_words == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    rd_en_d       = 1'b1;
                    rd_addr_d     = {bank_q, next_idx_q};
                    rd_count_d    = w_burst;
                    req_rem_d     = req_rem_q - w_burst;
                    next_idx_d    = next_idx_q + w_burst[ADDR_WIDTH-1:0];
                    outstanding_d = CNT_W'(w_burst);
                end else if (w_push) begin
                    outstanding_d = outstanding_q - CNT_W'(1);
                end
                if (w_pop) begin
                    pop_rem_d = pop_rem_q - AW'(1);
                    if (pop_rem_q == AW'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_adv) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_clr) begin
            w_cnt_d = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_cnt_d = w_count + CNT_W'(1);
                2'b01:   w_cnt_d = w_count - CNT_W'(1);
                default: w_cnt_d = w_count;
            endcase
        end
        // Registered view of "head available in RUN, or draining".
        out_valid_d = ((state_d == ST_RUN) && (w_cnt_d != '0)) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bank_q        <= 1'b0;
            next_idx_q    <= '0;
            req_rem_q     <= '0;
            pop_rem_q     <= '0;
            outstanding_q <= '0;
            drain_cnt_q   <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_count_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            next_idx_q    <= next_idx_d;
            req_rem_q     <= req_rem_d;
            pop_rem_q     <= pop_rem_d;
            outstanding_q <= outstanding_d;
            drain_cnt_q   <= drain_cnt_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_count_q    <= rd_count_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign w_skew_in = ((state_q == ST_RUN) && !w_empty) ? w_head : '0;

    // Lane i sees the word shifted in i advances ago; lane 0 is the live head.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        if (gi == 0) begin : g_direct
            assign out_data[0 +: LANE_W] = w_skew_in[0 +: LANE_W];
        end else begin : g_delay
            logic [LANE_W-1:0] sh_q [gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < gi; s++) begin
                        sh_q[s] <= '0;
                    end
                end else if (w_clr) begin
                    for (int s = 0; s < gi; s++) begin
                        sh_q[s] <= '0;
                    end
                end else if (w_adv) begin
                    sh_q[0] <= w_skew_in[gi*LANE_W +: LANE_W];
                    for (int s = 1; s < gi; s++) begin
                        sh_q[s] <= sh_q[s-1];
                    end
                end
            end

            assign out_data[gi*LANE_W +: LANE_W] = sh_q[gi-1];
        end
    end

    assign ub_rd_en    = rd_en_q;
    assign ub_rd_addr  = rd_addr_q;
    assign ub_rd_count = rd_count_q;
    assign out_valid   = out_valid_q;
    assign out_last    = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_ub_act_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ub_act_feeder
//  Description : Self-checking bench for ub_act_feeder with a unified-buffer
//                responder and a lane-level reference of the skewed stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ub_act_feeder;
    import tpu_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic                  clk         = 1'b0;
    logic                  rst_n       = 1'b1;
    logic                  start       = 1'b0;
    logic [8:0]            base_addr   = '0;
    logic [8:0]            num_words   = '0;
    logic                  ub_rd_en;
    logic [8:0]            ub_rd_addr;
    logic [8:0]            ub_rd_count;
    logic [DATA_WIDTH-1:0] ub_rd_data  = '0;
    logic                  ub_rd_valid = 1'b0;
    logic                  out_valid;
    logic                  out_ready   = 1'b1;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    always #5 clk = ~clk;

    ub_act_feeder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .ub_rd_en    (ub_rd_en),
        .ub_rd_addr  (ub_rd_addr),
        .ub_rd_count (ub_rd_count),
        .ub_rd_data  (ub_rd_data),
        .ub_rd_valid (ub_rd_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    typedef struct { logic [8:0] addr; int due; } pend_t;
    typedef struct { logic [8:0] addr; logic [8:0] cnt; } burst_t;

    logic [DATA_WIDTH-1:0] ub_mem [512];
    pend_t                 pend[$];
    burst_t                bursts[$];
    logic [DATA_WIDTH-1:0] beats[$];
    logic                  lasts[$];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, start_cyc = 0, last_beat_cyc = 0;
    int valid_cycles = 0, stall_err = 0, overlap_err = 0;
    logic                  prev_stall = 1'b0;
    logic [DATA_WIDTH-1:0] prev_data  = '0;
    logic                  prev_last  = 1'b0;
    logic [8:0]            cmd_base   = '0;
    int                    cmd_n      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Unified buffer: first word two cycles after the request, one per cycle.
    always begin
        @(posedge clk);
        #1;
        ub_rd_valid = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            ub_rd_data  = ub_mem[pend[0].addr];
            ub_rd_valid = 1'b1;
            void'(pend.pop_front());
        end
        if (rst_n && ub_rd_en) begin
            if (pend.size() != 0) overlap_err++;
            bursts.push_back('{addr: ub_rd_addr, cnt: ub_rd_count});
            for (int j = 0; j < int'(ub_rd_count); j++) begin
                pend.push_back('{addr: {ub_rd_addr[8], ub_rd_addr[7:0] + 8'(j)}, due: cyc + 2 + j});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
                last_beat_cyc = cyc;
            end
            if (out_valid) valid_cycles++;
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Beat k, lane i = lane i of row (k-i) of the command, zero outside the rows.
    function automatic logic [DATA_WIDTH-1:0] exp_beat(int k);
        logic [DATA_WIDTH-1:0] r;
        logic [8:0]            a;
        int                    j;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            j = k - i;
            if (j >= 0 && j < cmd_n) begin
                a = {cmd_base[8], cmd_base[7:0] + 8'(j)};
                r[i*LANE_W +: LANE_W] = ub_mem[a][i*LANE_W +: LANE_W];
            end
        end
        return r;
    endfunction

    task automatic run_cmd(input logic [8:0] base, input logic [8:0] n, input bit rnd_ready,
                           input int inj_at, output bit timed_out);
        beats.delete(); lasts.delete(); bursts.delete();
        done_cnt = 0; valid_cycles = 0; stall_err = 0; overlap_err = 0;
        cmd_base = base;
        cmd_n    = int'(n);
        @(posedge clk); #1;
        base_addr = base; num_words = n; start = 1'b1; start_cyc = cyc; out_ready = 1'b1;
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == inj_at) begin
                start = 1'b1; base_addr = ~base; num_words = 9'd3;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        bursts.delete();
        rst_n = 1'b1; start = 1'b1; base_addr = 9'h055; num_words = 9'd5;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({ub_rd_en, ub_rd_addr, ub_rd_count, out_valid, out_last, busy, done} !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b addr=%h cnt=%h valid=%b last=%b busy=%b done=%b data=%h, required all zero",
                     ub_rd_en, ub_rd_addr, ub_rd_count, out_valid, out_last, busy, done, out_data);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || bursts.size() != 0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b bursts=%0d, required busy=0 bursts=0", busy, bursts.size());
        end
    endtask

    task automatic test_single();
        bit to;
        run_cmd(9'h005, 9'd1, 1'b0, -1, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL single_timeout: done not seen, required done"); end
        n_tests++;
        if (bursts.size() != 1 || bursts[0].addr !== 9'h005 || bursts[0].cnt !== 9'd1) begin
            n_fail++;
            $display("FAIL single_burst: %0d bursts first addr %h cnt %0d, required 1 burst addr 005 cnt 1",
                     bursts.size(), bursts.size() ? bursts[0].addr : 9'h0, bursts.size() ? bursts[0].cnt : 9'h0);
        end
        n_tests++;
        if (beats.size() != 32) begin
            n_fail++; $display("FAIL single_beats: got %0d beats, required 32", beats.size());
        end
        for (int k = 0; k < beats.size() && k < 32; k++) begin
            n_tests++;
            if (beats[k] !== exp_beat(k) || lasts[k] !== (k == 31)) begin
                n_fail++;
                $display("FAIL single_beat %0d: got %h last %b, required %h last %b", k, beats[k], lasts[k], exp_beat(k), k == 31);
            end
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != last_beat_cyc + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: pulses %0d at +%0d busy %b, required 1 pulse at +1 busy 0",
                     done_cnt, done_cyc - last_beat_cyc, busy);
        end
    endtask

    task automatic test_stream(input string tag, input logic [8:0] base, input logic [8:0] n,
                               input bit rnd_ready, input int inj_at);
        bit   to;
        int   iss, rem, nb, lim;
        logic [8:0] ea;
        run_cmd(base, n, rnd_ready, inj_at, to);
        nb = int'(n) + LANES - 1;
        n_tests++;
        if (to) begin n_fail++; $display("FAIL %s_timeout: done not seen, required done", tag); end
        iss = 0;
        rem = int'(n);
        foreach (bursts[b]) begin
            ea  = {base[8], base[7:0] + 8'(iss)};
            lim = (rem < FIFO_DEPTH) ? rem : FIFO_DEPTH;
            n_tests++;
            if (bursts[b].addr !== ea || bursts[b].cnt == 0 || int'(bursts[b].cnt) > lim) begin
                n_fail++;
                $display("FAIL %s_burst %0d: addr %h cnt %0d, required addr %h cnt 1..%0d",
                         tag, b, bursts[b].addr, bursts[b].cnt, ea, lim);
            end
            iss += int'(bursts[b].cnt);
            rem -= int'(bursts[b].cnt);
        end
        n_tests++;
        if (iss != int'(n) || overlap_err != 0 || stall_err != 0) begin
            n_fail++;
            $display("FAIL %s_protocol: words requested %0d overlap %0d stall %0d, required %0d 0 0",
                     tag, iss, overlap_err, stall_err, n);
        end
        n_tests++;
        if (beats.size() != nb) begin
            n_fail++; $display("FAIL %s_beats: got %0d beats, required %0d", tag, beats.size(), nb);
        end
        for (int k = 0; k < beats.size() && k < nb; k++) begin
            n_tests++;
            if (beats[k] !== exp_beat(k) || lasts[k] !== (k == nb - 1)) begin
                n_fail++;
                $display("FAIL %s_beat %0d: got %h last %b, required %h last %b",
                         tag, k, beats[k], lasts[k], exp_beat(k), k == nb - 1);
            end
        end
        n_tests++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_done: pulses %0d busy %b, required 1 and 0", tag, done_cnt, busy);
        end
    endtask

    task automatic test_zero();
        bit to;
        run_cmd(9'h0AB, 9'd0, 1'b0, -1, to);
        n_tests++;
        if (to || done_cnt != 1 || (done_cyc - start_cyc) < 1 || (done_cyc - start_cyc) > 2) begin
            n_fail++;
            $display("FAIL zero_done: timeout %b pulses %0d delay %0d, required 0 1 1..2",
                     to, done_cnt, done_cyc - start_cyc);
        end
        n_tests++;
        if (bursts.size() != 0 || valid_cycles != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: bursts %0d valid cycles %0d busy %b, required 0 0 0",
                     bursts.size(), valid_cycles, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit got_en;
        got_en = 1'b0;
        bursts.delete();
        @(posedge clk); #1;
        base_addr = 9'h0F0; num_words = 9'd8; start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ub_rd_en) begin got_en = 1'b1; break; end
        end
        n_tests++;
        if (!got_en) begin n_fail++; $display("FAIL rstmid_issue: no ub_rd_en, required a burst"); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ub_rd_en, out_valid, out_last, busy, done} !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: en=%b valid=%b last=%b busy=%b done=%b, required all zero",
                     ub_rd_en, out_valid, out_last, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bursts.delete();
        for (int c = 0; c < 20 && pend.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || bursts.size() != 0 || pend.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_stray: busy=%b bursts=%0d pending=%0d, required 0 0 0", busy, bursts.size(), pend.size());
        end
        test_stream("rstmid", 9'h13C, 9'd2, 1'b0, -1);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            for (int w = 0; w < DATA_WIDTH / 32; w++) begin
                ub_mem[a][w*32 +: 32] = $urandom;
            end
        end
        test_reset();
        test_single();
        test_stream("wrap", 9'h1FE, 9'd10, 1'b0, -1);
        test_stream("bp", 9'h07C, 9'd6, 1'b1, 8);
        test_zero();
        test_reset_mid();
        for (int r = 0; r < 3; r++) begin
            test_stream("rand", 9'($urandom_range(0, 511)), 9'($urandom_range(1, 12)), 1'b1, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
